// File: rtl/dino_frame_writer.sv
// Per-frame game-state updater for the dino sprite display: advances jump physics, pose and cactus
// scroll on each VGA_VS falling edge, then streams ten sprite-position register writes over Avalon-MM.
module dino_frame_writer #(
    parameter logic [7:0] DINO_X    = 8'd100,
    parameter logic [7:0] GROUND_Y  = 8'd100,
    parameter logic [7:0] JUMP_V    = 8'd12,
    parameter logic [7:0] GRAVITY   = 8'd1,
    parameter logic [7:0] SPEED     = 8'd4,
    parameter logic [7:0] CAC_START = 8'd250,
    parameter logic [7:0] CAC_Y     = 8'd100,
    parameter logic [7:0] GODZ_X    = 8'd100,
    parameter logic [7:0] GODZ_Y    = 8'd200,
    parameter logic [7:0] PARK_X    = 8'd0,
    parameter logic [7:0] PARK_Y    = 8'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vga_vs,
    input  logic        jump_req,
    input  logic        duck_req,
    output logic [8:0]  address,
    output logic [31:0] writedata,
    output logic        write,
    output logic        chipselect,
    input  logic        waitrequest,
    output logic        overrun,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_UPDATE = 2'd1, ST_WRITE = 2'd2} state_t;
    typedef enum logic [1:0] {POSE_RUN = 2'd0, POSE_JUMP = 2'd1, POSE_DUCK = 2'd2} pose_t;

    state_t             state_q, state_d;
    pose_t              pose_q, pose_d;
    logic               vs_q;
    logic               jump_cap_q, jump_cap_d;
    logic               duck_cap_q, duck_cap_d;
    logic [7:0]         y_q, y_d;
    logic signed [7:0]  v_q, v_d;
    logic [7:0]         cac_q, cac_d;
    logic               write_q, write_d;
    logic [8:0]         address_q, address_d;
    logic [31:0]        writedata_q, writedata_d;
    logic               overrun_q, overrun_d;

    logic               frame_start;
    logic               grounded;
    logic               jump_start;
    logic signed [7:0]  v_tmp;
    logic [9:0]         y_sum;
    logic signed [9:0]  y_new;
    logic [7:0]         y_upd;
    logic signed [7:0]  v_upd;
    logic [7:0]         cac_upd;
    pose_t              pose_upd;

    assign frame_start = vs_q & ~vga_vs;

    function automatic logic [7:0] beat_val(input logic [3:0] idx, input pose_t pose,
                                            input logic [7:0] y, input logic [7:0] cx);
        logic [7:0] val;
        val = 8'd0;
        case (idx)
            4'd0: val = (pose == POSE_RUN)  ? DINO_X   : PARK_X;
            4'd1: val = (pose == POSE_RUN)  ? y        : PARK_Y;
            4'd2: val = (pose == POSE_JUMP) ? DINO_X   : PARK_X;
            4'd3: val = (pose == POSE_JUMP) ? y        : PARK_Y;
            4'd4: val = (pose == POSE_DUCK) ? DINO_X   : PARK_X;
            4'd5: val = (pose == POSE_DUCK) ? GROUND_Y : PARK_Y;
            4'd6: val = cx;
            4'd7: val = CAC_Y;
            4'd8: val = GODZ_X;
            4'd9: val = GODZ_Y;
            default: val = 8'd0;
        endcase
        return val;
    endfunction

    // Physics for the frame: y/v evaluated in 10-bit signed so upward overshoot clamps at the top.
    always_comb begin
        grounded   = (y_q == GROUND_Y) && (v_q == 8'sd0);
        jump_start = grounded && jump_cap_q;
        v_tmp      = jump_start ? $signed(8'd0 - JUMP_V) : v_q;
        y_sum      = {2'b00, y_q} + {{2{v_tmp[7]}}, v_tmp};
        y_new      = $signed(y_sum);
        y_upd      = y_q;
        v_upd      = v_q;
        if (!grounded || jump_start) begin
            if (y_new < 10'sd0) begin
                y_upd = 8'd0;
                v_upd = v_tmp + $signed(GRAVITY);
            end else if ((v_tmp > 8'sd0) && (y_new >= $signed({2'b00, GROUND_Y}))) begin
                y_upd = GROUND_Y;
                v_upd = 8'sd0;
            end else begin
                y_upd = y_sum[7:0];
                v_upd = v_tmp + $signed(GRAVITY);
            end
        end
        if (!((y_upd == GROUND_Y) && (v_upd == 8'sd0))) begin
            pose_upd = POSE_JUMP;
        end else if (grounded && !jump_start && duck_cap_q) begin
            pose_upd = POSE_DUCK;
        end else begin
            pose_upd = POSE_RUN;
        end
        cac_upd = (cac_q < SPEED) ? CAC_START : (cac_q - SPEED);
    end

    // Avalon write handshake: address/writedata/write are registered and held while
    // write && waitrequest; a beat retires on write && !waitrequest and the next beat follows at once.
    always_comb begin
        state_d     = state_q;
        pose_d      = pose_q;
        jump_cap_d  = jump_cap_q;
        duck_cap_d  = duck_cap_q;
        y_d         = y_q;
        v_d         = v_q;
        cac_d       = cac_q;
        write_d     = write_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        overrun_d   = overrun_q | (frame_start && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d    = ST_UPDATE;
                    jump_cap_d = jump_req;
                    duck_cap_d = duck_req;
                end
            end
            ST_UPDATE: begin
                y_d         = y_upd;
                v_d         = v_upd;
                pose_d      = pose_upd;
                cac_d       = cac_upd;
                state_d     = ST_WRITE;
                write_d     = 1'b1;
                address_d   = 9'd0;
                writedata_d = {24'd0, beat_val(4'd0, pose_upd, y_upd, cac_upd)};
            end
            ST_WRITE: begin
                if (write_q && !waitrequest) begin
                    if (address_q == 9'd9) begin
                        write_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        address_d   = address_q + 9'd1;
                        writedata_d = {24'd0, beat_val(address_q[3:0] + 4'd1, pose_q, y_q, cac_q)};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pose_q      <= POSE_RUN;
            vs_q        <= 1'b1;
            jump_cap_q  <= 1'b0;
            duck_cap_q  <= 1'b0;
            y_q         <= GROUND_Y;
            v_q         <= 8'sd0;
            cac_q       <= CAC_START;
            write_q     <= 1'b0;
            address_q   <= 9'd0;
            writedata_q <= 32'd0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pose_q      <= pose_d;
            vs_q        <= vga_vs;
            jump_cap_q  <= jump_cap_d;
            duck_cap_q  <= duck_cap_d;
            y_q         <= y_d;
            v_q         <= v_d;
            cac_q       <= cac_d;
            write_q     <= write_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            overrun_q   <= overrun_d;
        end
    end

    assign address     = address_q;
    assign writedata   = writedata_q;
    assign write       = write_q;
    assign chipselect  = write_q;
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;

endmodule
